pe_os_accum: RTL and testbench

- Output-stationary systolic processing element for the integer/fixed-point tile of the matrix engine. It forwards activations east and weights south with one register stage each.
- It accumulates a dot product of run-time length locally, using a 2-stage multiply-accumulate (MAC) pipeline.
- Finished sums leave through a ready/valid drain chain that also relays results from upstream PEs in the same column.
- It replaces the single-shot vendor-MAC PE, adding accumulation, tile framing, backpressure and overrun detection.

---
 rtl/pe_os_accum.sv | 152 +++++++++++++++
 tb/tb_pe_os_accum.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_os_accum.sv
// Output-stationary PE: forwards operands (1 cycle), 2-stage MAC, result out 3 cycles after last pair.
// Forwarding never stalls; drain backpressure holds result_o, and a sum finishing on a full res sets overrun_o.
module pe_os_accum #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter bit SATURATE   = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] input_i,
    input  logic                  input_valid_i,
    input  logic                  input_last_i,
    input  logic [DATA_WIDTH-1:0] weight_i,
    input  logic                  weight_valid_i,
    output logic [DATA_WIDTH-1:0] input_o,
    output logic                  input_valid_o,
    output logic                  input_last_o,
    output logic [DATA_WIDTH-1:0] weight_o,
    output logic                  weight_valid_o,
    input  logic [ACC_WIDTH-1:0]  chain_data_i,
    input  logic                  chain_valid_i,
    output logic                  chain_ready_o,
    output logic [ACC_WIDTH-1:0]  result_o,
    output logic                  result_valid_o,
    input  logic                  result_ready_i,
    output logic                  busy_o,
    output logic                  overrun_o,
    input  logic                  clear_err_i
);

    localparam int SUM_W = ACC_WIDTH + 1;
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic {
        ACC_IDLE = 1'b0,
        ACC_RUN  = 1'b1
    } acc_state_t;

    acc_state_t                    r_state;
    acc_state_t                    w_state_nxt;
    logic signed [2*DATA_WIDTH-1:0] r_prod;
    logic                          r_p_valid;
    logic                          r_p_last;
    logic signed [ACC_WIDTH-1:0]   r_acc;
    logic        [ACC_WIDTH-1:0]   r_res;
    logic                          r_res_full;

    logic                          w_fire;
    logic signed [ACC_WIDTH-1:0]   w_prod_ext;
    logic signed [ACC_WIDTH-1:0]   w_base;
    logic signed [SUM_W-1:0]       w_sum_wide;
    logic                          w_ovf;
    logic        [ACC_WIDTH-1:0]   w_sum;
    logic                          w_out_free;
    logic                          w_res_move;
    logic                          w_res_wr;
    logic                          w_ovr_set;

    assign w_fire     = input_valid_i & weight_valid_i;
    assign w_prod_ext = ACC_WIDTH'(r_prod);
    // ACC_IDLE doubles as acc_zero: a fresh sum ignores whatever r_acc holds.
    assign w_base     = (r_state == ACC_IDLE) ? '0 : r_acc;
    assign w_sum_wide = SUM_W'(w_base) + SUM_W'(w_prod_ext);
    assign w_ovf      = w_sum_wide[ACC_WIDTH] ^ w_sum_wide[ACC_WIDTH-1];

    always_comb begin
        w_sum = w_sum_wide[ACC_WIDTH-1:0];
        if (SATURATE && w_ovf) begin
            w_sum = w_sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_p_valid) begin
            w_state_nxt = r_p_last ? ACC_IDLE : ACC_RUN;
        end
    end

    assign w_out_free    = ~result_valid_o | result_ready_i;
    assign w_res_move    = w_out_free & r_res_full;
    assign w_res_wr      = r_p_valid & r_p_last & (~r_res_full | w_res_move);
    assign w_ovr_set     = r_p_valid & r_p_last & r_res_full & ~w_res_move;
    assign chain_ready_o = w_out_free & ~r_res_full;
    assign busy_o        = (r_state == ACC_RUN) | r_p_valid | r_res_full;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            input_o        <= '0;
            input_valid_o  <= 1'b0;
            input_last_o   <= 1'b0;
            weight_o       <= '0;
            weight_valid_o <= 1'b0;
            r_prod         <= '0;
            r_p_valid      <= 1'b0;
            r_p_last       <= 1'b0;
            r_state        <= ACC_IDLE;
            r_acc          <= '0;
        end else begin
            input_o        <= input_i;
            input_valid_o  <= input_valid_i;
            input_last_o   <= input_last_i;
            weight_o       <= weight_i;
            weight_valid_o <= weight_valid_i;
            r_prod         <= $signed(input_i) * $signed(weight_i);
            r_p_valid      <= w_fire;
            r_p_last       <= w_fire & input_last_i;
            r_state        <= w_state_nxt;
            if (r_p_valid) begin
                r_acc <= w_sum;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_res          <= '0;
            r_res_full     <= 1'b0;
            result_o       <= '0;
            result_valid_o <= 1'b0;
            overrun_o      <= 1'b0;
        end else begin
            if (w_res_wr) begin
                r_res      <= w_sum;
                r_res_full <= 1'b1;
            end else if (w_res_move) begin
                r_res_full <= 1'b0;
            end

            // Local result beats the chain so the sink-nearest PE drains first.
            if (w_out_free) begin
                if (r_res_full) begin
                    result_o       <= r_res;
                    result_valid_o <= 1'b1;
                end else if (chain_valid_i) begin
                    result_o       <= chain_data_i;
                    result_valid_o <= 1'b1;
                end else begin
                    result_valid_o <= 1'b0;
                end
            end

            if (w_ovr_set) begin
                overrun_o <= 1'b1;
            end else if (clear_err_i) begin
                overrun_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pe_os_accum.sv
// Bench for pe_os_accum: directed scenarios plus randomized tiles against a queue-based dot-product model.
module tb_pe_os_accum;

    localparam int DW = 16;
    localparam int AW = 40;

    logic                 clk_i = 1'b0;
    logic                 rst_n;
    logic signed [DW-1:0] input_i, weight_i;
    logic                 input_valid_i, input_last_i, weight_valid_i;
    logic [AW-1:0]        chain_data_i;
    logic                 chain_valid_i, result_ready_i, clear_err_i;

    logic [DW-1:0] input_o, weight_o;
    logic          input_valid_o, input_last_o, weight_valid_o, chain_ready_o;
    logic [AW-1:0] result_o;
    logic          result_valid_o, busy_o, overrun_o;

    logic [DW-1:0] s_in_o, s_wt_o, w_in_o, w_wt_o;
    logic          s_iv_o, s_il_o, s_wv_o, s_cr_o, s_rv_o, s_busy, s_ovr;
    logic          w_iv_o, w_il_o, w_wv_o, w_cr_o, w_rv_o, w_busy, w_ovr;
    logic [31:0]   s_res, w_res;
    logic [31:0]   c32 = '0;
    logic          lo = 1'b0;
    logic          hi = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    pe_os_accum #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .SATURATE(1'b0)) u_dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .input_i(input_i), .input_valid_i(input_valid_i), .input_last_i(input_last_i),
        .weight_i(weight_i), .weight_valid_i(weight_valid_i),
        .input_o(input_o), .input_valid_o(input_valid_o), .input_last_o(input_last_o),
        .weight_o(weight_o), .weight_valid_o(weight_valid_o),
        .chain_data_i(chain_data_i), .chain_valid_i(chain_valid_i), .chain_ready_o(chain_ready_o),
        .result_o(result_o), .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .busy_o(busy_o), .overrun_o(overrun_o), .clear_err_i(clear_err_i)
    );

    pe_os_accum #(.DATA_WIDTH(DW), .ACC_WIDTH(32), .SATURATE(1'b1)) u_sat (
        .clk_i(clk_i), .rst_n(rst_n),
        .input_i(input_i), .input_valid_i(input_valid_i), .input_last_i(input_last_i),
        .weight_i(weight_i), .weight_valid_i(weight_valid_i),
        .input_o(s_in_o), .input_valid_o(s_iv_o), .input_last_o(s_il_o),
        .weight_o(s_wt_o), .weight_valid_o(s_wv_o),
        .chain_data_i(c32), .chain_valid_i(lo), .chain_ready_o(s_cr_o),
        .result_o(s_res), .result_valid_o(s_rv_o), .result_ready_i(hi),
        .busy_o(s_busy), .overrun_o(s_ovr), .clear_err_i(lo)
    );

    pe_os_accum #(.DATA_WIDTH(DW), .ACC_WIDTH(32), .SATURATE(1'b0)) u_wrap (
        .clk_i(clk_i), .rst_n(rst_n),
        .input_i(input_i), .input_valid_i(input_valid_i), .input_last_i(input_last_i),
        .weight_i(weight_i), .weight_valid_i(weight_valid_i),
        .input_o(w_in_o), .input_valid_o(w_iv_o), .input_last_o(w_il_o),
        .weight_o(w_wt_o), .weight_valid_o(w_wv_o),
        .chain_data_i(c32), .chain_valid_i(lo), .chain_ready_o(w_cr_o),
        .result_o(w_res), .result_valid_o(w_rv_o), .result_ready_i(hi),
        .busy_o(w_busy), .overrun_o(w_ovr), .clear_err_i(lo)
    );

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic iv, input logic wv, input logic last,
                         input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
        input_valid_i  = iv;
        weight_valid_i = wv;
        input_last_i   = last;
        input_i        = a;
        weight_i       = b;
    endtask

    task automatic pair(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b, input logic last);
        drive(1'b1, 1'b1, last, a, b);
    endtask

    task automatic idle;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference for a SATURATE=1, 32-bit accumulator: clamp after every addition.
    function automatic longint clamp32(input longint v);
        if (v > 64'sd2147483647)  return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    logic [AW-1:0]        exp_q[$];
    longint               m_acc;
    longint               m_sat;
    longint               m_wrap;
    longint               prod;
    logic [63:0]          tmp64;
    logic signed [DW-1:0] ra, rb;
    logic                 riv, rwv, rlast;
    logic [DW-1:0]        prev_a;
    logic                 prev_iv, prev_last;

    initial begin
        rst_n          = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 16'sd77, 16'sd33);
        chain_data_i   = '0;
        chain_valid_i  = 1'b0;
        result_ready_i = 1'b1;
        clear_err_i    = 1'b0;
        tick;
        tick;
        chk("rst_input_o", input_o, 0);
        chk("rst_input_valid_o", input_valid_o, 0);
        chk("rst_input_last_o", input_last_o, 0);
        chk("rst_weight_o", weight_o, 0);
        chk("rst_weight_valid_o", weight_valid_o, 0);
        chk("rst_result_o", result_o, 0);
        chk("rst_result_valid_o", result_valid_o, 0);
        chk("rst_overrun_o", overrun_o, 0);
        chk("rst_busy_o", busy_o, 0);
        chk("rst_chain_ready_o", chain_ready_o, 1);
        idle;
        rst_n = 1'b1;
        tick;

        // Basic dot product: 3*4 + -2*5 + 7*7 = 51, valid three cycles after last.
        pair(16'sd3, 16'sd4, 1'b0);  tick;
        chk("fwd_input_o", input_o, 3);
        chk("fwd_weight_o", weight_o, 4);
        pair(-16'sd2, 16'sd5, 1'b0); tick;
        chk("busy_mid_tile", busy_o, 1);
        pair(16'sd7, 16'sd7, 1'b1);  tick;
        chk("fwd_input_last_o", input_last_o, 1);
        chk("t1_valid_early_a", result_valid_o, 0);
        idle; tick;
        chk("t1_valid_early_b", result_valid_o, 0);
        tick;
        chk("t1_valid", result_valid_o, 1);
        chk("t1_result", result_o, 51);
        tick;
        chk("t1_valid_once", result_valid_o, 0);
        chk("t1_busy_after", busy_o, 0);

        // Back-to-back tiles with no bubble: 1+4 = 5, then fresh 25.
        pair(16'sd1, 16'sd1, 1'b0); tick;
        pair(16'sd2, 16'sd2, 1'b1); tick;
        pair(16'sd5, 16'sd5, 1'b1); tick;
        idle; tick;
        chk("b2b_first_valid", result_valid_o, 1);
        chk("b2b_first", result_o, 5);
        tick;
        chk("b2b_second_valid", result_valid_o, 1);
        chk("b2b_second", result_o, 25);
        tick;
        chk("b2b_done", result_valid_o, 0);

        // Backpressure with a pending chain value: local 12 held, then 12 and 0x99 in order.
        result_ready_i = 1'b0;
        pair(16'sd3, 16'sd4, 1'b1); tick;
        idle; tick; tick;
        chk("bp_local_valid", result_valid_o, 1);
        chk("bp_local", result_o, 12);
        chain_valid_i = 1'b1;
        chain_data_i  = 40'h99;
        #1;
        chk("bp_chain_ready_low", chain_ready_o, 0);
        tick; tick;
        chk("bp_hold_result", result_o, 12);
        chk("bp_hold_valid", result_valid_o, 1);
        chk("bp_hold_chain_ready", chain_ready_o, 0);
        result_ready_i = 1'b1;
        #1;
        chk("bp_chain_ready_high", chain_ready_o, 1);
        tick;
        chain_valid_i = 1'b0;
        chk("bp_chain_valid", result_valid_o, 1);
        chk("bp_chain_data", result_o, 40'h99);
        tick;
        chk("bp_drained", result_valid_o, 0);

        // Overrun: three single-pair tiles with the drain stalled.
        result_ready_i = 1'b0;
        pair(16'sd2, 16'sd3, 1'b1); tick;
        idle; tick;
        pair(16'sd2, 16'sd3, 1'b1); tick;
        idle; tick;
        pair(16'sd2, 16'sd3, 1'b1); tick;
        idle; tick; tick; tick; tick;
        chk("ovr_out_result", result_o, 6);
        chk("ovr_out_valid", result_valid_o, 1);
        chk("ovr_flag", overrun_o, 1);
        chk("ovr_busy_res_full", busy_o, 1);
        result_ready_i = 1'b1;
        #1;
        chk("ovr_chain_ready_res_full", chain_ready_o, 0);
        tick;
        chk("ovr_second_valid", result_valid_o, 1);
        chk("ovr_second", result_o, 6);
        tick;
        chk("ovr_third_dropped", result_valid_o, 0);
        chk("ovr_sticky", overrun_o, 1);
        chk("ovr_busy_after", busy_o, 0);
        clear_err_i = 1'b1; tick;
        clear_err_i = 1'b0;
        chk("ovr_cleared", overrun_o, 0);

        // Saturation vs wrap on 32-bit accumulators; the 40-bit DUT holds the exact sum.
        for (int n = 2; n <= 3; n++) begin
            for (int neg = 0; neg < 2; neg++) begin
                prod   = (neg != 0) ? -64'sd32768 * 64'sd32767 : 64'sd32768 * 64'sd32768;
                m_sat  = 0;
                m_wrap = 0;
                for (int k = 0; k < n; k++) begin
                    pair(-16'sd32768, (neg != 0) ? 16'sd32767 : -16'sd32768, (k == n - 1));
                    tick;
                    m_sat  = clamp32(m_sat + prod);
                    m_wrap = m_wrap + prod;
                end
                idle; tick; tick;
                chk("sat_valid", s_rv_o, 1);
                tmp64 = m_sat;
                chk("sat_result", s_res, tmp64[31:0]);
                tmp64 = m_wrap;
                chk("wrap_result", w_res, tmp64[31:0]);
                chk("wide_result", result_o, tmp64[AW-1:0]);
                tick;
            end
        end

        // Unpaired activations must not accumulate; then reset mid-tile.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, k[0], 16'sd9, 16'sd9);
            tick;
        end
        chk("unpaired_iv_fwd", input_valid_o, 1);
        chk("unpaired_wv_fwd", weight_valid_o, 0);
        idle; tick; tick; tick;
        chk("unpaired_no_result", result_valid_o, 0);
        chk("unpaired_not_busy", busy_o, 0);
        pair(16'sd10, 16'sd10, 1'b0); tick;
        pair(16'sd10, 16'sd10, 1'b0); tick;
        idle; tick;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy_o, 0);
        chk("midrst_input_o", input_o, 0);
        chk("midrst_result_valid", result_valid_o, 0);
        chk("midrst_result", result_o, 0);
        chk("midrst_overrun", overrun_o, 0);
        #2;
        rst_n = 1'b1;
        tick;
        pair(16'sd1, 16'sd2, 1'b1); tick;
        idle; tick; tick;
        chk("postrst_valid", result_valid_o, 1);
        chk("postrst_result", result_o, 2);
        tick;

        // Randomized tiles, drain always ready; model is a running dot product per tile.
        m_acc     = 0;
        prev_a    = '0;
        prev_iv   = 1'b0;
        prev_last = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc > 0) begin
                chk("rnd_fwd_input", input_o, prev_a);
                chk("rnd_fwd_valid", input_valid_o, prev_iv);
                chk("rnd_fwd_last", input_last_o, prev_last);
            end
            if (result_valid_o) begin
                if (exp_q.size() == 0) chk("rnd_unexpected_result", 1, 0);
                else chk("rnd_result", result_o, exp_q.pop_front());
            end
            case ($urandom_range(0, 9))
                6:       begin riv = 1'b1; rwv = 1'b0; end
                7:       begin riv = 1'b0; rwv = 1'b1; end
                8, 9:    begin riv = 1'b0; rwv = 1'b0; end
                default: begin riv = 1'b1; rwv = 1'b1; end
            endcase
            ra    = DW'($urandom);
            rb    = DW'($urandom);
            rlast = ($urandom_range(0, 3) == 0);
            drive(riv, rwv, rlast, ra, rb);
            prev_a    = ra;
            prev_iv   = riv;
            prev_last = rlast;
            if (riv && rwv) begin
                prod  = ra * rb;
                m_acc = m_acc + prod;
                if (rlast) begin
                    tmp64 = m_acc;
                    exp_q.push_back(tmp64[AW-1:0]);
                    m_acc = 0;
                end
            end
            tick;
        end
        idle;
        for (int k = 0; k < 10; k++) begin
            if (result_valid_o) begin
                if (exp_q.size() == 0) chk("rnd_unexpected_result", 1, 0);
                else chk("rnd_result", result_o, exp_q.pop_front());
            end
            tick;
        end
        chk("rnd_drain_empty", exp_q.size(), 0);
        chk("rnd_no_overrun", overrun_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
